// File: rtl/pcseq_pkg.sv
// ============================================================================
// Module  : pcseq_pkg
// Brief   : Shared types and constants for the PC sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pcseq_pkg;

    localparam int PC_W = 32;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pcseq_state_t;

    typedef enum logic [2:0] {
        SEL_RESET  = 3'd0,
        SEL_HOLD   = 3'd1,
        SEL_RET    = 3'd2,
        SEL_TARGET = 3'd3,
        SEL_SEQ    = 3'd4,
        SEL_TRAP   = 3'd5
    } npc_sel_t;

endpackage

`default_nettype wire

// File: rtl/pc_ret_stack.sv
// ============================================================================
// Module  : pc_ret_stack
// Brief   : DEPTH x PC_W return-address LIFO; Rst clears the pointer only.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_ret_stack
    import pcseq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Push_i,
    input  logic                       Pop_i,
    input  logic [PC_W-1:0]            PushData_i,
    output logic [PC_W-1:0]            Top_o,
    output logic [$clog2(DEPTH):0]     Depth_o,
    output logic                       Full_o,
    output logic                       Empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [PC_W-1:0] mem_q [DEPTH];
    logic [DW-1:0]   depth_q;
    logic [DW-1:0]   depth_d;
    logic [AW-1:0]   top_idx;

    assign Full_o  = (depth_q == DW'(DEPTH));
    assign Empty_o = (depth_q == '0);
    assign Depth_o = depth_q;

    // Read index wraps when empty; the sequencer never consumes Top_o then.
    assign top_idx = depth_q[AW-1:0] - AW'(1);
    assign Top_o   = mem_q[top_idx];

    always_comb begin
        depth_d = depth_q;
        if (Push_i && !Full_o) begin
            depth_d = depth_q + DW'(1);
        end else if (Pop_i && !Empty_o) begin
            depth_d = depth_q - DW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst && Push_i && !Full_o) begin
            mem_q[depth_q[AW-1:0]] <= PushData_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module  : pc_sequencer
// Brief   : Next-PC controller with return stack and BOOT/RUN/HALTED FSM.
//           Optional macro PCSEQ_TRAP_EN vectors stack faults to TRAP_ADDR.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
    import pcseq_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] PC_STEP    = 32'd4,
    parameter int          RS_DEPTH   = 16,
    parameter logic [31:0] TRAP_ADDR  = 32'h0000_0100
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic [31:0]                 PC,
    input  logic                        Stall,
    input  logic                        Jmp,
    input  logic                        Jz,
    input  logic                        Zero,
    input  logic                        Call,
    input  logic                        Ret,
    input  logic                        Halt,
    input  logic                        Resume,
    input  logic [31:0]                 Target,
    output logic [31:0]                 nPC,
    output logic [$clog2(RS_DEPTH):0]   RsDepth,
    output logic                        Ovf,
    output logic                        Unf,
    output logic                        Halted
);

    pcseq_state_t state_q, state_d;
    npc_sel_t     sel;
    logic         push, pop;
    logic         ovf_set, unf_set;
    logic         ovf_q, unf_q;
    logic         rs_full, rs_empty;
    logic [31:0]  rs_top;
    logic [31:0]  pc_seq;

    assign pc_seq = PC + PC_STEP;

    pc_ret_stack #(
        .DEPTH      (RS_DEPTH)
    ) u_ret_stack (
        .Clk        (Clk),
        .Rst        (Rst),
        .Push_i     (push),
        .Pop_i      (pop),
        .PushData_i (pc_seq),
        .Top_o      (rs_top),
        .Depth_o    (RsDepth),
        .Full_o     (rs_full),
        .Empty_o    (rs_empty)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= BOOT;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ovf_set) ovf_q <= 1'b1;
            if (unf_set) unf_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        sel     = SEL_SEQ;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (Rst) begin
            sel = SEL_RESET;
        end else begin
            case (state_q)
                BOOT: begin
                    sel     = SEL_RESET;
                    state_d = RUN;
                end
                RUN: begin
                    if (Halt) begin
                        sel     = SEL_HOLD;
                        state_d = HALTED;
                    end else if (Stall) begin
                        sel = SEL_HOLD;
                    end else if (Ret) begin
                        if (rs_empty) begin
                            unf_set = 1'b1;
`ifdef PCSEQ_TRAP_EN
                            sel = SEL_TRAP;
`else
                            sel = SEL_SEQ;
`endif
                        end else begin
                            pop = 1'b1;
                            sel = SEL_RET;
                        end
                    end else if (Call) begin
                        if (rs_full) begin
                            ovf_set = 1'b1;
`ifdef PCSEQ_TRAP_EN
                            sel = SEL_TRAP;
`else
                            sel = SEL_TARGET;
`endif
                        end else begin
                            push = 1'b1;
                            sel  = SEL_TARGET;
                        end
                    end else if (Jmp || (Jz && Zero)) begin
                        sel = SEL_TARGET;
                    end else begin
                        sel = SEL_SEQ;
                    end
                end
                HALTED: begin
                    sel = SEL_HOLD;
                    // Halt held alongside Resume keeps the core parked.
                    if (Resume && !Halt) state_d = RUN;
                end
                default: begin
                    sel     = SEL_RESET;
                    state_d = BOOT;
                end
            endcase
        end
    end

    always_comb begin
        nPC = pc_seq;
        case (sel)
            SEL_RESET:  nPC = RESET_ADDR;
            SEL_HOLD:   nPC = PC;
            SEL_RET:    nPC = rs_top;
            SEL_TARGET: nPC = Target;
            SEL_SEQ:    nPC = pc_seq;
            SEL_TRAP:   nPC = TRAP_ADDR;
            default:    nPC = pc_seq;
        endcase
    end

    assign Ovf    = ovf_q;
    assign Unf    = unf_q;
    assign Halted = (state_q == HALTED);

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module  : tb_pc_sequencer
// Brief   : Directed self-checking bench for pc_sequencer (default build).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] PC;
    logic        Stall, Jmp, Jz, Zero, Call, Ret, Halt, Resume;
    logic [31:0] Target;
    logic [31:0] nPC;
    logic [4:0]  RsDepth;
    logic        Ovf, Unf, Halted;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    pc_sequencer dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .PC      (PC),
        .Stall   (Stall),
        .Jmp     (Jmp),
        .Jz      (Jz),
        .Zero    (Zero),
        .Call    (Call),
        .Ret     (Ret),
        .Halt    (Halt),
        .Resume  (Resume),
        .Target  (Target),
        .nPC     (nPC),
        .RsDepth (RsDepth),
        .Ovf     (Ovf),
        .Unf     (Unf),
        .Halted  (Halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Move to the low phase and clear all controls.
    task automatic tick();
        @(negedge Clk);
        Stall = 0; Jmp = 0; Jz = 0; Zero = 0; Call = 0; Ret = 0;
        Halt = 0; Resume = 0;
    endtask

    initial begin
        Rst = 1; PC = 0; Target = 0;
        Stall = 0; Jmp = 0; Jz = 0; Zero = 0; Call = 0; Ret = 0;
        Halt = 0; Resume = 0;

        // Reset for two cycles
        @(negedge Clk);
        @(negedge Clk);
        #1;
        chk("rst_npc", nPC, 32'h0);
        chk("rst_depth", 32'(RsDepth), 32'd0);
        chk("rst_ovf", 32'(Ovf), 32'd0);
        chk("rst_unf", 32'(Unf), 32'd0);
        chk("rst_halted", 32'(Halted), 32'd0);

        // BOOT cycle ignores controls
        tick(); Rst = 0; PC = 32'h40; Jmp = 1; Target = 32'h999; #1;
        chk("boot_npc", nPC, 32'h0);

        tick(); PC = 32'h0; #1;
        chk("run_seq", nPC, 32'h4);

        // Call then Ret
        tick(); PC = 32'h40; Call = 1; Target = 32'h200; #1;
        chk("call_npc", nPC, 32'h200);
        tick(); #1;
        chk("call_depth", 32'(RsDepth), 32'd1);
        PC = 32'h208; Ret = 1; #1;
        chk("ret_npc", nPC, 32'h44);
        tick(); #1;
        chk("ret_depth", 32'(RsDepth), 32'd0);

        // Jz / Stall / Jmp
        PC = 32'h10; Jz = 1; Target = 32'h80; Zero = 1; #1;
        chk("jz_taken", nPC, 32'h80);
        Zero = 0; #1;
        chk("jz_not_taken", nPC, 32'h14);
        Jz = 0; Stall = 1; Jmp = 1; #1;
        chk("stall_over_jmp", nPC, 32'h10);
        Stall = 0; #1;
        chk("jmp", nPC, 32'h80);
        Jmp = 0; PC = 32'hFFFF_FFFC; #1;
        chk("seq_wrap", nPC, 32'h0);

        // Fill stack, then one overflowing Call
        for (int i = 0; i < 17; i++) begin
            tick(); PC = 32'h1000 + 32'(i) * 32'h10; Call = 1; Target = 32'h2000 + 32'(i); #1;
            chk("call_fill_npc", nPC, 32'h2000 + 32'(i));
        end
        tick(); #1;
        chk("full_depth", 32'(RsDepth), 32'd16);
        chk("ovf_set", 32'(Ovf), 32'd1);
        chk("unf_clear", 32'(Unf), 32'd0);

        // Ret beats Call: top entry is from call 15
        PC = 32'h5000; Ret = 1; Call = 1; Target = 32'h7777; #1;
        chk("ret_over_call", nPC, 32'h10F4);
        tick(); #1;
        chk("ret_over_call_depth", 32'(RsDepth), 32'd15);
        for (int i = 14; i >= 0; i--) begin
            PC = 32'h6000; Ret = 1; #1;
            chk("unwind_npc", nPC, 32'h1000 + 32'(i) * 32'h10 + 32'h4);
            tick();
        end
        #1;
        chk("unwind_depth", 32'(RsDepth), 32'd0);

        // Underflow
        PC = 32'h30; Ret = 1; #1;
        chk("unf_npc", nPC, 32'h34);
        tick(); #1;
        chk("unf_set", 32'(Unf), 32'd1);
        chk("unf_depth", 32'(RsDepth), 32'd0);
        chk("ovf_sticky", 32'(Ovf), 32'd1);

        // Reset clears flags
        Rst = 1; Ret = 1; #1;
        chk("rst_mid_npc", nPC, 32'h0);
        tick(); #1;
        chk("rst_clr_unf", 32'(Unf), 32'd0);
        chk("rst_clr_ovf", 32'(Ovf), 32'd0);
        Rst = 0;
        tick();  // BOOT

        // Halt / Resume
        PC = 32'h50; Halt = 1; Call = 1; Target = 32'h300; #1;
        chk("halt_npc", nPC, 32'h50);
        for (int i = 0; i < 5; i++) begin
            tick(); Jmp = 1; Target = 32'h300; #1;
            chk("halted_flag", 32'(Halted), 32'd1);
            chk("halted_npc", nPC, 32'h50);
        end
        chk("halt_no_push", 32'(RsDepth), 32'd0);
        Halt = 1; Resume = 1; #1;
        chk("halt_resume_npc", nPC, 32'h50);
        tick(); #1;
        chk("halt_resume_stay", 32'(Halted), 32'd1);
        Resume = 1; #1;
        chk("resume_npc", nPC, 32'h50);
        tick(); Jmp = 1; Target = 32'h300; #1;
        chk("resumed_flag", 32'(Halted), 32'd0);
        chk("resumed_jmp", nPC, 32'h300);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
